// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, parity modes and frame helper for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Number of bit periods in one frame: start + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing an end-of-bit tick
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
      $error("uart_baud_gen: CLKS_PER_BIT out of range 2..65535");
    end
  endgenerate

  // Count 0..CLKS_PER_BIT-1 and wrap; clr holds the count at zero so a new bit starts aligned.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with ready/valid payload input
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 TxD,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic ODD_PAR = (PARITY == PAR_ODD);
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 ||
        (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        FRAME_BITS > 13) begin : g_bad_params
      $error("uart_tx_cfg: illegal DATA_BITS, PARITY or STOP_BITS");
    end
  endgenerate

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [BIT_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 par_bit;
  logic                 tick;
  logic                 baud_clr;
  logic                 accept;

  assign accept   = tx_valid && tx_ready;
  // Counter is held clear while idle, so the acceptance edge starts the start bit at count zero.
  assign baud_clr = (state == S_IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (baud_clr),
    .tick (tick)
  );

  // Frame sequencer; every output is registered and the line is driven to the next bit on each tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      TxD      <= 1'b1;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          TxD <= 1'b1;
          if (accept) begin
            state    <= S_START;
            TxD      <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            shift    <= tx_data;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bit  <= (^tx_data) ^ ODD_PAR;
          end
        end
        S_START: begin
          if (tick) begin
            state <= S_DATA;
            TxD   <= shift[0];
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              if (PARITY != PAR_NONE) begin
                state <= S_PARITY;
                TxD   <= par_bit;
              end else begin
                state <= S_STOP;
                TxD   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              TxD     <= shift[1];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state <= S_STOP;
            TxD   <= 1'b1;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (stop_idx == LAST_STOP) begin
              state    <= S_IDLE;
              TxD      <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          TxD      <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [8:0] tx_data = '0;
  logic       rdy_a  [5];
  logic       txd_a  [5];
  logic       busy_a [5];
  logic       done_a [5];

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] line;
  int done_cnt, done_first, done_last;
  logic busy_first;

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 7E2, 4: 9N1
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data[7:0]),
    .tx_ready(rdy_a[0]), .TxD(txd_a[0]), .tx_busy(busy_a[0]), .tx_done(done_a[0]));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data[7:0]),
    .tx_ready(rdy_a[1]), .TxD(txd_a[1]), .tx_busy(busy_a[1]), .tx_done(done_a[1]));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data[7:0]),
    .tx_ready(rdy_a[2]), .TxD(txd_a[2]), .tx_busy(busy_a[2]), .tx_done(done_a[2]));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data[6:0]),
    .tx_ready(rdy_a[3]), .TxD(txd_a[3]), .tx_busy(busy_a[3]), .tx_done(done_a[3]));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1)) u_9n1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(rdy_a[4]), .TxD(txd_a[4]), .tx_busy(busy_a[4]), .tx_done(done_a[4]));

  task automatic do_reset();
    reset = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Caller sets tx_valid/tx_data at a negedge; cycle 1 is the cycle after the acceptance edge.
  task automatic run_capture(input int k, input int n,
                             input int ca, input logic va, input logic [8:0] da,
                             input int cb, input logic vb, input logic [8:0] db);
    line = '1;
    done_cnt = 0;
    done_first = 0;
    done_last = 0;
    busy_first = 1'b0;
    @(negedge clk);
    for (int c = 1; c <= n; c++) begin
      if (c == ca) begin tx_valid = va; tx_data = da; end
      if (c == cb) begin tx_valid = vb; tx_data = db; end
      line[c] = txd_a[k];
      if (c == 1) busy_first = busy_a[k];
      if (done_a[k] === 1'b1) begin
        done_cnt++;
        if (done_first == 0) done_first = c;
        done_last = c;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (rdy_a[0] !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", rdy_a[0]); end
    n_cmp++; if (busy_a[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy_a[0]); end
    n_cmp++; if (txd_a[0] !== 1'b1) begin n_bad++; $display("FAIL reset_txd got=%b exp=1", txd_a[0]); end
    n_cmp++; if (done_a[0] !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done_a[0]); end
    // reset wins over a simultaneous acceptance
    tx_valid = 1'b1;
    tx_data = 9'h055;
    @(negedge clk);
    reset = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy_a[0] !== 1'b0) begin n_bad++; $display("FAIL reset_priority_busy got=%b exp=0", busy_a[0]); end
    n_cmp++; if (txd_a[0] !== 1'b1) begin n_bad++; $display("FAIL reset_priority_txd got=%b exp=1", txd_a[0]); end
  endtask

  task automatic test_8n1();
    logic e [10] = '{0,1,0,1,0,0,1,0,1,1};
    do_reset();
    tx_valid = 1'b1;
    tx_data = 9'h0A5;
    run_capture(0, 48, 1, 1'b0, 9'h0A5, 0, 1'b0, 9'h0);
    n_cmp++; if (busy_first !== 1'b1) begin n_bad++; $display("FAIL 8n1_busy got=%b exp=1", busy_first); end
    for (int b = 0; b < 10; b++) begin
      n_cmp++;
      if (line[4*b+1 +: 4] !== {4{e[b]}}) begin
        n_bad++; $display("FAIL 8n1_bit%0d got=%b exp=%b", b, line[4*b+1 +: 4], {4{e[b]}});
      end
    end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL 8n1_done_count got=%0d exp=1", done_cnt); end
    n_cmp++; if (done_first !== 41) begin n_bad++; $display("FAIL 8n1_done_cycle got=%0d exp=41", done_first); end
    n_cmp++; if (line[48:41] !== 8'hFF) begin n_bad++; $display("FAIL 8n1_idle_mark got=%b exp=11111111", line[48:41]); end
  endtask

  task automatic test_parity();
    int ks [3] = '{1, 2, 3};
    logic [8:0] ds [3] = '{9'h007, 9'h007, 9'h055};
    logic e [3][11] = '{'{0,1,1,1,0,0,0,0,0,1,1},
                        '{0,1,1,1,0,0,0,0,0,0,1},
                        '{0,1,0,1,0,1,0,1,0,1,1}};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      tx_valid = 1'b1;
      tx_data = ds[t];
      run_capture(ks[t], 50, 1, 1'b0, ds[t], 0, 1'b0, 9'h0);
      for (int b = 0; b < 11; b++) begin
        n_cmp++;
        if (line[4*b+1 +: 4] !== {4{e[t][b]}}) begin
          n_bad++; $display("FAIL parity_case%0d_bit%0d got=%b exp=%b", t, b, line[4*b+1 +: 4], {4{e[t][b]}});
        end
      end
      n_cmp++; if (done_first !== 45) begin n_bad++; $display("FAIL parity_case%0d_done_cycle got=%0d exp=45", t, done_first); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL parity_case%0d_done_count got=%0d exp=1", t, done_cnt); end
    end
  endtask

  task automatic test_nine_bits();
    do_reset();
    tx_valid = 1'b1;
    tx_data = 9'h1FF;
    run_capture(4, 50, 1, 1'b0, 9'h1FF, 0, 1'b0, 9'h0);
    n_cmp++; if (line[4:1] !== 4'h0) begin n_bad++; $display("FAIL 9n1_start got=%b exp=0000", line[4:1]); end
    n_cmp++; if (line[44:5] !== {40{1'b1}}) begin n_bad++; $display("FAIL 9n1_data_stop got=%h exp=all ones", line[44:5]); end
    n_cmp++; if (done_first !== 45) begin n_bad++; $display("FAIL 9n1_done_cycle got=%0d exp=45", done_first); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tx_valid = 1'b1;
    tx_data = 9'h000;
    run_capture(0, 90, 2, 1'b1, 9'h0FF, 42, 1'b0, 9'h0FF);
    n_cmp++; if (line[36:1] !== 36'h0) begin n_bad++; $display("FAIL b2b_frame0_low got=%h exp=0", line[36:1]); end
    n_cmp++; if (line[41:37] !== 5'h1F) begin n_bad++; $display("FAIL b2b_stop_mark got=%b exp=11111", line[41:37]); end
    n_cmp++; if (line[45:42] !== 4'h0) begin n_bad++; $display("FAIL b2b_start1 got=%b exp=0000", line[45:42]); end
    n_cmp++; if (line[90:46] !== {45{1'b1}}) begin n_bad++; $display("FAIL b2b_frame1_high got=%h exp=all ones", line[90:46]); end
    n_cmp++; if (done_cnt !== 2) begin n_bad++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
    n_cmp++; if (done_first !== 41) begin n_bad++; $display("FAIL b2b_done_first got=%0d exp=41", done_first); end
    n_cmp++; if (done_last !== 82) begin n_bad++; $display("FAIL b2b_done_last got=%0d exp=82", done_last); end
  endtask

  task automatic test_midframe_change();
    logic e0 [10] = '{0,1,1,0,0,0,0,1,1,1};
    logic e1 [10] = '{0,0,0,1,1,1,1,0,0,1};
    do_reset();
    tx_valid = 1'b1;
    tx_data = 9'h0C3;
    run_capture(0, 90, 10, 1'b1, 9'h03C, 42, 1'b0, 9'h03C);
    for (int b = 0; b < 10; b++) begin
      n_cmp++;
      if (line[4*b+1 +: 4] !== {4{e0[b]}}) begin
        n_bad++; $display("FAIL mid_c3_bit%0d got=%b exp=%b", b, line[4*b+1 +: 4], {4{e0[b]}});
      end
      n_cmp++;
      if (line[4*b+42 +: 4] !== {4{e1[b]}}) begin
        n_bad++; $display("FAIL mid_3c_bit%0d got=%b exp=%b", b, line[4*b+42 +: 4], {4{e1[b]}});
      end
    end
    n_cmp++; if (line[41] !== 1'b1) begin n_bad++; $display("FAIL mid_mark got=%b exp=1", line[41]); end
    n_cmp++; if (done_cnt !== 2) begin n_bad++; $display("FAIL mid_done_count got=%0d exp=2", done_cnt); end
  endtask

  task automatic test_abort();
    logic e [10] = '{0,1,0,0,0,0,0,0,1,1};
    int   n_done;
    logic all_high;
    do_reset();
    tx_valid = 1'b1;
    tx_data = 9'h000;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (13) @(negedge clk);
    n_cmp++; if (txd_a[0] !== 1'b0) begin n_bad++; $display("FAIL abort_bit2_low got=%b exp=0", txd_a[0]); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (txd_a[0] !== 1'b1) begin n_bad++; $display("FAIL abort_txd got=%b exp=1", txd_a[0]); end
    n_cmp++; if (rdy_a[0] !== 1'b1) begin n_bad++; $display("FAIL abort_ready got=%b exp=1", rdy_a[0]); end
    n_cmp++; if (busy_a[0] !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy_a[0]); end
    n_done = 0;
    all_high = 1'b1;
    for (int c = 0; c < 45; c++) begin
      if (done_a[0] !== 1'b0) n_done++;
      if (txd_a[0] !== 1'b1) all_high = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
    n_cmp++; if (all_high !== 1'b1) begin n_bad++; $display("FAIL abort_line_idle got=%b exp=1", all_high); end
    tx_valid = 1'b1;
    tx_data = 9'h081;
    run_capture(0, 48, 1, 1'b0, 9'h081, 0, 1'b0, 9'h0);
    for (int b = 0; b < 10; b++) begin
      n_cmp++;
      if (line[4*b+1 +: 4] !== {4{e[b]}}) begin
        n_bad++; $display("FAIL after_abort_bit%0d got=%b exp=%b", b, line[4*b+1 +: 4], {4{e[b]}});
      end
    end
    n_cmp++; if (done_first !== 41) begin n_bad++; $display("FAIL after_abort_done got=%0d exp=41", done_first); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_nine_bits();
    test_back_to_back();
    test_midframe_change();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
